// File: rtl/dmem_2r1w_if.sv
// dmem_2r1w_if: access bus for the dmem_2r1w data memory.
// The master drives the addresses, write data, byte mask and requests.
// The memory returns both read words, the read-valid pulse and ready.
interface dmem_2r1w_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0]   addr;
  logic [ADDR_W-1:0]   addr2;
  logic [DATA_W-1:0]   write_data;
  logic [DATA_W/8-1:0] byte_en;
  logic                MemWrite;
  logic                MemRead;
  logic [DATA_W-1:0]   read_data;
  logic [DATA_W-1:0]   read_data2;
  logic                read_valid;
  logic                ready;

  modport master (
    output addr, addr2, write_data, byte_en, MemWrite, MemRead,
    input  read_data, read_data2, read_valid, ready
  );

  modport slave (
    input  addr, addr2, write_data, byte_en, MemWrite, MemRead,
    output read_data, read_data2, read_valid, ready
  );
endinterface

// File: rtl/dmem_2r1w.sv
// dmem_2r1w: synchronous data memory with one byte-masked write port and
// two registered read ports. After reset a clear sequencer zeroes every word
// before any access is accepted; ready marks the end of that sweep.
// Optional feature macro DMEM_WRITE_BYPASS_EN: when defined, a read of the
// word being written on the same edge returns the merged (new) word;
// otherwise the read returns the word as it was before that edge.
module dmem_2r1w #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input logic        clk,
  input logic        rst,
  dmem_2r1w_if.slave bus
);

  localparam int NBYTES = DATA_W / 8;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   clr_idx;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                addr_ok;
  logic                addr2_ok;
  logic [DATA_W-1:0]   old_word;
  logic [DATA_W-1:0]   old_word2;
  logic [DATA_W-1:0]   merged_word;
  logic [DATA_W-1:0]   rd_word;
  logic [DATA_W-1:0]   rd_word2;

  logic                ready_q;
  logic                read_valid_q;
  logic [DATA_W-1:0]   read_data_q;
  logic [DATA_W-1:0]   read_data2_q;

  // Look up both addressed words (0 when out of range) and build the
  // byte-merged word a write at addr would store.
  always_comb begin
    addr_ok   = int'(bus.addr) < DEPTH;
    addr2_ok  = int'(bus.addr2) < DEPTH;
    old_word  = addr_ok ? mem[bus.addr] : '0;
    old_word2 = addr2_ok ? mem[bus.addr2] : '0;
    merged_word = old_word;
    for (int b = 0; b < NBYTES; b++) begin
      if (bus.byte_en[b]) begin
        merged_word[8*b +: 8] = bus.write_data[8*b +: 8];
      end
    end
  end

  // Select what each read port captures when it shares the write address.
  always_comb begin
`ifdef DMEM_WRITE_BYPASS_EN
    rd_word  = (bus.MemWrite && addr_ok) ? merged_word : old_word;
    rd_word2 = (bus.MemWrite && addr_ok && (bus.addr2 == bus.addr)) ?
               merged_word : old_word2;
`else
    rd_word  = old_word;
    rd_word2 = old_word2;
`endif
  end

  // Array storage: zero one word per edge while clearing, otherwise apply
  // in-range byte-masked writes.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[clr_idx] <= '0;
    end else if (bus.MemWrite && addr_ok) begin
      mem[bus.addr] <= merged_word;
    end
  end

  // Sequencer and registered read outputs; accesses are ignored until the
  // clear sweep reaches the last word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= CLEAR;
      clr_idx      <= '0;
      ready_q      <= 1'b0;
      read_valid_q <= 1'b0;
      read_data_q  <= '0;
      read_data2_q <= '0;
    end else begin
      case (state)
        CLEAR: begin
          read_valid_q <= 1'b0;
          read_data_q  <= '0;
          read_data2_q <= '0;
          if (clr_idx == LAST_IDX) begin
            state   <= RUN;
            ready_q <= 1'b1;
            clr_idx <= '0;
          end else begin
            clr_idx <= clr_idx + ADDR_W'(1);
          end
        end
        default: begin
          read_valid_q <= bus.MemRead;
          if (bus.MemRead) begin
            read_data_q <= rd_word;
          end
          read_data2_q <= rd_word2;
        end
      endcase
    end
  end

  assign bus.ready      = ready_q;
  assign bus.read_valid = read_valid_q;
  assign bus.read_data  = read_data_q;
  assign bus.read_data2 = read_data2_q;

endmodule

// File: tb/tb_dmem_2r1w.sv
// tb_dmem_2r1w: scoreboard bench for dmem_2r1w (DEPTH=24, ADDR_W=5, so
// addresses 24..31 are out of range). The driver pushes expected responses
// computed from an array model; a monitor pops and compares after each edge.
// Honours DMEM_WRITE_BYPASS_EN in the model the same way the design does.
module tb_dmem_2r1w;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 24;
  localparam int ADDR_W = 5;
  localparam int NBYTES = DATA_W / 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  dmem_2r1w_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  dmem_2r1w #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic        rv;
    logic [31:0] rd2;
  } exp_t;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] model_mem [DEPTH];
  exp_t        exp_q[$];
  logic [31:0] rd1_q[$];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t",
               name, actual, expected, $time);
    end
  endtask

  function automatic logic [31:0] modelRead(input int a);
    return (a < DEPTH) ? model_mem[a] : 32'h0;
  endfunction

  function automatic logic [31:0] byteMerge(input logic [31:0] old_w,
                                            input logic [31:0] new_w,
                                            input logic [3:0] be);
    logic [31:0] mask;
    mask = 32'h0;
    for (int b = 0; b < NBYTES; b++) begin
      if (be[b]) mask = mask | (32'hFF << (8 * b));
    end
    return (old_w & ~mask) | (new_w & mask);
  endfunction

  function automatic void modelClear();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
  endfunction

  // Drive one access cycle at a negedge, record what it must produce, and
  // advance to the next negedge.
  task automatic applyStimulus(input logic we, input logic re, input int a,
                               input int a2, input logic [31:0] wd,
                               input logic [3:0] be);
    logic [31:0] old1, old2, new1, r1, r2;
    logic        collide;
    exp_t        e;
    bus.MemWrite   = we;
    bus.MemRead    = re;
    bus.addr       = ADDR_W'(a);
    bus.addr2      = ADDR_W'(a2);
    bus.write_data = wd;
    bus.byte_en    = be;
    if (bus.ready && !rst) begin
      old1    = modelRead(a);
      old2    = modelRead(a2);
      collide = we && (a < DEPTH);
      new1    = collide ? byteMerge(old1, wd, be) : old1;
`ifdef DMEM_WRITE_BYPASS_EN
      r1 = new1;
      r2 = (collide && a2 == a) ? new1 : old2;
`else
      r1 = old1;
      r2 = old2;
`endif
      if (re) rd1_q.push_back(r1);
      e.rv  = re;
      e.rd2 = r2;
      exp_q.push_back(e);
      if (collide) model_mem[a] = new1;
    end
    @(negedge clk);
  endtask

  task automatic checkAsyncZero(input string tag);
    #1;
    checkOutput({tag, "_rd"},    bus.read_data,  32'h0);
    checkOutput({tag, "_rd2"},   bus.read_data2, 32'h0);
    checkOutput({tag, "_rv"},    32'(bus.read_valid), 32'h0);
    checkOutput({tag, "_ready"}, 32'(bus.ready),      32'h0);
  endtask

  // Reset, then count edges to ready while driving junk requests; when
  // abort_at > 0, reassert reset after that many clear edges and restart.
  task automatic resetSequence(input int abort_at);
    int k;
    bit aborted;
    aborted = 1'b0;
    #2 rst = 1'b1;
    modelClear();
    checkAsyncZero("async_rst");
    @(negedge clk);
    rst = 1'b0;
    k = 0;
    while (k < DEPTH) begin
      bus.MemWrite   = 1'($urandom);
      bus.MemRead    = 1'b1;
      bus.addr       = ADDR_W'($urandom_range(0, 31));
      bus.addr2      = ADDR_W'($urandom_range(0, 31));
      bus.write_data = $urandom;
      bus.byte_en    = 4'hF;
      @(posedge clk);
      #1;
      k++;
      checkOutput("ready_rise", 32'(bus.ready), 32'(k == DEPTH));
      @(negedge clk);
      if (k == abort_at && !aborted) begin
        aborted = 1'b1;
        #2 rst = 1'b1;
        checkAsyncZero("midclear_rst");
        @(negedge clk);
        rst = 1'b0;
        k = 0;
      end
    end
  endtask

  // Monitor: after each edge, compare outputs with the oldest expectation
  // when that edge was a RUN edge, otherwise require quiet zero outputs.
  initial begin
    logic        run_edge;
    logic        run;
    logic [31:0] held;
    logic [31:0] r1;
    exp_t        e;
    held = 32'h0;
    forever begin
      @(negedge clk);
      run_edge = bus.ready && !rst;
      @(posedge clk);
      #1;
      run = run_edge && !rst;
      if (run) begin
        if (exp_q.size() == 0) begin
          checkOutput("exp_q_underflow", 32'(exp_q.size()), 32'h1);
        end else begin
          e = exp_q.pop_front();
          checkOutput("read_valid", 32'(bus.read_valid), 32'(e.rv));
          checkOutput("read_data2", bus.read_data2, e.rd2);
          if (bus.read_valid) begin
            if (rd1_q.size() == 0) begin
              checkOutput("rd1_q_underflow", 32'(rd1_q.size()), 32'h1);
            end else begin
              r1 = rd1_q.pop_front();
              held = r1;
              checkOutput("read_data", bus.read_data, r1);
            end
          end else begin
            checkOutput("read_data_hold", bus.read_data, held);
          end
        end
      end else begin
        held = 32'h0;
        checkOutput("clear_rv",  32'(bus.read_valid), 32'h0);
        checkOutput("clear_rd",  bus.read_data,  32'h0);
        checkOutput("clear_rd2", bus.read_data2, 32'h0);
      end
    end
  end

  // Main sequence: garbage fill, reset clear, directed cases, random traffic,
  // mid-run and mid-clear resets.
  initial begin
    int a;
    bus.MemWrite   = 1'b0;
    bus.MemRead    = 1'b0;
    bus.addr       = '0;
    bus.addr2      = '0;
    bus.write_data = '0;
    bus.byte_en    = '0;
    modelClear();
    @(negedge clk);
    @(negedge clk);
    resetSequence(0);

    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, 1'b0, i, i, $urandom | 32'h1, 4'hF);
    end
    resetSequence(0);
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b0, 1'b1, i, 31 - i, 32'h0, 4'h0);
    end

    applyStimulus(1'b1, 1'b0, 6, 0, 32'd6, 4'hF);
    applyStimulus(1'b0, 1'b1, 6, 6, 32'h0, 4'h0);
    applyStimulus(1'b0, 1'b1, 0, 6, 32'h0, 4'h0);
    applyStimulus(1'b0, 1'b1, 1, 1, 32'h0, 4'h0);
    applyStimulus(1'b0, 1'b1, 2, 2, 32'h0, 4'h0);

    applyStimulus(1'b1, 1'b0, 3, 0, 32'h11223344, 4'hF);
    applyStimulus(1'b1, 1'b0, 3, 0, 32'hAABBCCDD, 4'b0010);
    applyStimulus(1'b0, 1'b1, 3, 3, 32'h0, 4'h0);

    applyStimulus(1'b1, 1'b0, 9, 0, 32'h0000_0005, 4'hF);
    applyStimulus(1'b1, 1'b1, 9, 9, 32'h0000_0007, 4'hF);
    applyStimulus(1'b0, 1'b1, 9, 9, 32'h0, 4'h0);

    applyStimulus(1'b1, 1'b0, 30, 0, 32'hDEAD_BEEF, 4'hF);
    applyStimulus(1'b0, 1'b1, 30, 30, 32'h0, 4'h0);
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b0, 1'b1, i, DEPTH - 1 - i, 32'h0, 4'h0);
    end

    for (int i = 0; i < 400; i++) begin
      a = $urandom_range(0, 31);
      applyStimulus(1'($urandom), 1'($urandom), a,
                    ($urandom_range(0, 3) == 0) ? a : $urandom_range(0, 31),
                    $urandom, 4'($urandom));
    end

    applyStimulus(1'b1, 1'b0, 4, 4, 32'hCAFE_F00D, 4'hF);
    applyStimulus(1'b0, 1'b1, 4, 4, 32'h0, 4'h0);
    resetSequence(10);
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b0, 1'b1, i, i, 32'h0, 4'h0);
    end
    for (int i = 0; i < 40; i++) begin
      a = $urandom_range(0, 31);
      applyStimulus(1'($urandom), 1'b1, a, a, $urandom, 4'($urandom));
    end

    bus.MemWrite = 1'b0;
    bus.MemRead  = 1'b0;
    #2;
    checkOutput("exp_q_drained", 32'(exp_q.size()), 32'h0);
    checkOutput("rd1_q_drained", 32'(rd1_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_2r1w.md
# dmem_2r1w

Parametrised synchronous data memory for the datapath: one write port with byte enables and two independent read ports (`addr` and `addr2`), with registered read outputs. After reset, a built-in clear sequencer zeroes every word before the memory accepts any access, and `ready` reports completion. It replaces the unclocked 32x32 data memory in the processor's MEM stage. The second read port serves debug and forwarding taps.

## Interface
- `DATA_W`, 32: word width in bits; must be a multiple of 8.
- `DEPTH`, 32: number of words; need not be a power of two.
- `ADDR_W`, 5: address width; must satisfy 2^ADDR_W >= DEPTH.

- `clk` in 1: the single clock; all state changes on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `addr` in ADDR_W: write address, and read address for port 1.
- `addr2` in ADDR_W: read address for port 2.
- `write_data` in DATA_W: write word.
- `byte_en` in DATA_W/8: per-byte write mask; bit i covers bits [8i+7:8i].
- `MemWrite` in 1: write request.
- `MemRead` in 1: port-1 read request.
- `read_data` out DATA_W: registered port-1 read data.
- `read_data2` out DATA_W: registered port-2 read data; updated every ready cycle.
- `read_valid` out 1: one-cycle pulse marking new `read_data`.
- `ready` out 1: clear sequence done; accesses are accepted.

## Operation
- **States.**
  - CLEAR: counter `clr_idx` runs 0..DEPTH-1 and zeroes word `clr_idx` on each edge.
  - RUN: normal accesses.
- **Reset.** `rst`=1 asynchronously forces:
  - state to CLEAR, `clr_idx` to 0, `ready` to 0, `read_valid` to 0;
  - `read_data` and `read_data2` to 0.
  - The array itself has no reset; the CLEAR state zeroes it.
- **CLEAR to RUN.** The edge that zeroes word DEPTH-1 also sets `ready`=1 and moves to RUN.
- **Ignored during CLEAR.** `MemWrite`, `MemRead` and `addr2` are ignored. Outputs hold 0 and `read_valid` stays 0.
- **Write (RUN).** With `MemWrite`=1, each byte of word `addr` whose `byte_en` bit is 1 takes the matching byte of `write_data`. Other bytes are unchanged.
- **Port-1 read (RUN).**
  - `MemRead`=1: `read_data` <= word `addr`, and `read_valid` <= 1.
  - `MemRead`=0: `read_data` holds its value, and `read_valid` <= 0.
- **Port-2 read (RUN).** `read_data2` <= word `addr2` on every edge.
- **Out-of-range address (`addr` or `addr2` >= DEPTH).**
  - Writes to it are dropped.
  - Reads from it return 0; `read_valid` still pulses.
- **Simultaneous events.**
  - `MemRead` and `MemWrite` both 1 perform both accesses.
  - Read data for a port whose address equals the write address follows the Configuration rule. This applies to both ports.
- **Reset mid-CLEAR or mid-RUN.** Immediate return to CLEAR with `clr_idx`=0. The clear then restarts from word 0.

## Timing
- Read latency is 1 cycle: data sampled at edge N appears on the outputs after edge N.
- Write commits at the edge where it is requested. A read of the same word at edge N+1 returns the new value.
- `ready` rises exactly DEPTH rising edges after `rst` is released.
- `read_valid` is high for exactly one cycle per accepted read request. Back-to-back requests give a continuously high `read_valid`.

## Configuration
- Macro `DMEM_WRITE_BYPASS_EN` sets read-during-write behaviour at the same address.
- **Defined (write-first).** The read returns the merged word: new bytes where `byte_en`=1, old bytes elsewhere.
- **Undefined (read-first).** The read returns the word as it was before the write edge.

## Test plan
- **Reset clear.** DEPTH=32; preload garbage into the array through the simulator, pulse `rst`.
  - `ready`=0 for 31 edges, and =1 after the 32nd.
  - Then read all 32 addresses on both ports: every value is 0.
- **Basic write/read.** Write 6 to addr 6 with `byte_en`=4'hF.
  - Next cycle, `MemRead`=1 at addr 6 gives `read_data`=6 with a `read_valid` pulse.
  - Addr 0, 1 and 2 read 0. `addr2`=6 gives `read_data2`=6.
- **Byte enables.** Write 32'h11223344 to addr 3, then write 32'hAABBCCDD with `byte_en`=4'b0010. Reading addr 3 returns 32'h1122CC44.
- **Same-address read and write.** Word 9 holds 32'h0000_0005. Same edge: write 32'h0000_0007 at addr 9, `MemRead`=1, `addr2`=9.
  - With the macro defined, both ports return 7.
  - Without it, both return 5.
  - The following cycle, both return 7 in either build.
- **Out of range.** DEPTH=24, ADDR_W=5: write 32'hDEAD_BEEF to addr 30, then read addr 30.
  - `read_data`=0 with a `read_valid` pulse.
  - Words 0..23 are unchanged.
- **Reset mid-clear.** Assert `rst` at clear cycle 10 while `MemRead`=1.
  - Outputs go to 0 asynchronously.
  - After release, `ready` rises only after a full DEPTH edges.
  - No `read_valid` pulse occurs before `ready`.
